uart_cmd_responder: RTL and testbench



---
 rtl/uart_cmd_pkg.sv | 46 ++++
 rtl/uart_resp_sequencer.sv | 95 +++++++++
 rtl/uart_cmd_responder.sv | 133 +++++++++++++
 tb/tb_uart_cmd_responder.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_pkg
// Description : Shared constants for the UART command responder: response
//               FSM state encoding, ASCII command/response characters and a
//               helper that selects the byte to send for a given index.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_cmd_pkg;

    // Response FSM state encoding
    localparam int unsigned ST_W = 3;
    localparam logic [ST_W-1:0] ST_IDLE    = 3'd0;
    localparam logic [ST_W-1:0] ST_LOAD    = 3'd1;
    localparam logic [ST_W-1:0] ST_START   = 3'd2;
    localparam logic [ST_W-1:0] ST_WAIT_HI = 3'd3;
    localparam logic [ST_W-1:0] ST_WAIT_LO = 3'd4;

    // Command keys (upper case; received bytes are folded before compare)
    localparam logic [7:0] CMD_RUN    = 8'h52;  // 'R'
    localparam logic [7:0] CMD_STOP   = 8'h53;  // 'S'
    localparam logic [7:0] CMD_TOGGLE = 8'h54;  // 'T'
    localparam logic [7:0] CMD_CLEAR  = 8'h43;  // 'C'

    // Response characters
    localparam logic [7:0] CHR_CR  = 8'h0D;
    localparam logic [7:0] CHR_LF  = 8'h0A;
    localparam logic [7:0] CHR_ERR = 8'h3F;     // '?'

    // Clearing bit5 folds lower-case letters onto upper case
    localparam logic [7:0] CASE_MASK = 8'hDF;

    // Byte idx of the 3-byte response: echoed char, CR, LF
    function automatic logic [7:0] resp_byte(input logic [7:0] chr,
                                             input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = chr;
            2'd1:    b = CHR_CR;
            default: b = CHR_LF;
        endcase
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_resp_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : uart_resp_sequencer
// Description : Response FSM. Pops one response char from the pending buffer
//               and sends char/CR/LF through the transmitter handshake,
//               waiting for tx_busy to rise (or a timeout) and then fall
//               between bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_resp_sequencer
    import uart_cmd_pkg::*;
#(
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       buf_vld,
    input  logic [7:0] buf_chr,
    input  logic       tx_busy,
    output logic       buf_pop,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic       seq_busy
);

    localparam logic [7:0] C_TMO_LAST = 8'(BUSY_TIMEOUT - 1);

    logic [ST_W-1:0] r_state;
    logic [1:0]      r_idx;
    logic [7:0]      r_tmo;
    logic [7:0]      r_chr;
    logic            r_tx_start;
    logic [7:0]      r_tx_data;

    // Response FSM with registered tx handshake outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_idx      <= 2'd0;
            r_tmo      <= 8'd0;
            r_chr      <= 8'h00;
            r_tx_start <= 1'b0;
            r_tx_data  <= 8'h00;
        end else begin
            // tx_start is a single-cycle pulse; START is never re-entered
            // on the cycle right after it fires.
            r_tx_start <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (buf_vld) r_state <= ST_LOAD;
                end
                ST_LOAD: begin
                    r_chr   <= buf_chr;
                    r_idx   <= 2'd0;
                    r_state <= ST_START;
                end
                ST_START: begin
                    if (!tx_busy) begin
                        r_tx_start <= 1'b1;
                        r_tx_data  <= resp_byte(r_chr, r_idx);
                        r_tmo      <= 8'd0;
                        r_state    <= ST_WAIT_HI;
                    end
                end
                ST_WAIT_HI: begin
                    // A transmitter that never reports busy is assumed to
                    // have taken the byte once the timeout elapses.
                    if (tx_busy || (r_tmo == C_TMO_LAST)) begin
                        r_state <= ST_WAIT_LO;
                    end else begin
                        r_tmo <= r_tmo + 8'd1;
                    end
                end
                ST_WAIT_LO: begin
                    if (!tx_busy) begin
                        if (r_idx == 2'd2) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_idx   <= r_idx + 2'd1;
                            r_state <= ST_START;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign buf_pop  = (r_state == ST_LOAD);
    assign seq_busy = (r_state != ST_IDLE);
    assign tx_start = r_tx_start;
    assign tx_data  = r_tx_data;

endmodule
`default_nettype wire

// File: rtl/uart_cmd_responder.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_responder
// Description : Decodes single-character ASCII commands received over the
//               UART into counter run/clear controls and queues a 3-byte
//               echo response (char, CR, LF) for the transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_cmd_responder
    import uart_cmd_pkg::*;
#(
    parameter int ECHO_EN      = 1,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    input  logic       tx_busy,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic       run,
    output logic       clear,
    output logic       resp_busy,
    output logic       ovf
);

    logic       r_rx_vld;
    logic [7:0] r_rx_byte;
    logic       r_run;
    logic       r_clear;
    logic       r_buf_vld;
    logic [7:0] r_buf_chr;
    logic       r_ovf;

    logic [7:0] w_key;
    logic       w_cmd_valid;
    logic [7:0] w_resp_chr;
    logic       w_push;
    logic       w_pop;
    logic       w_seq_busy;

    // Capture the received byte; decode acts on this registered copy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_vld  <= 1'b0;
            r_rx_byte <= 8'h00;
        end else begin
            r_rx_vld <= rx_done;
            if (rx_done) r_rx_byte <= rx_data;
        end
    end

    assign w_key = r_rx_byte & CASE_MASK;

    // Classify the captured byte and choose its response character
    always_comb begin
        w_cmd_valid = 1'b0;
        case (w_key)
            CMD_RUN, CMD_STOP, CMD_TOGGLE, CMD_CLEAR: w_cmd_valid = 1'b1;
            default:                                  w_cmd_valid = 1'b0;
        endcase
        w_resp_chr = w_cmd_valid ? r_rx_byte : CHR_ERR;
    end

    // Apply run/clear actions regardless of response activity
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_run   <= 1'b0;
            r_clear <= 1'b0;
        end else begin
            r_clear <= 1'b0;
            if (r_rx_vld) begin
                case (w_key)
                    CMD_RUN:    r_run   <= 1'b1;
                    CMD_STOP:   r_run   <= 1'b0;
                    CMD_TOGGLE: r_run   <= ~r_run;
                    CMD_CLEAR:  r_clear <= 1'b1;
                    default:    ;
                endcase
            end
        end
    end

    generate
        if (ECHO_EN != 0) begin : g_echo
            assign w_push = r_rx_vld;
        end else begin : g_no_echo
            assign w_push = 1'b0;
        end
    endgenerate

    // One-entry pending buffer; a pop in the same cycle frees the slot first
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buf_vld <= 1'b0;
            r_buf_chr <= 8'h00;
            r_ovf     <= 1'b0;
        end else begin
            if (w_pop) r_buf_vld <= 1'b0;
            if (w_push) begin
                if (r_buf_vld && !w_pop) begin
                    // Keep the older response, flag the loss
                    r_ovf <= 1'b1;
                end else begin
                    r_buf_vld <= 1'b1;
                    r_buf_chr <= w_resp_chr;
                end
            end
        end
    end

    uart_resp_sequencer #(
        .BUSY_TIMEOUT (BUSY_TIMEOUT)
    ) u_seq (
        .clk      (clk),
        .rst      (rst),
        .buf_vld  (r_buf_vld),
        .buf_chr  (r_buf_chr),
        .tx_busy  (tx_busy),
        .buf_pop  (w_pop),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .seq_busy (w_seq_busy)
    );

    assign run       = r_run;
    assign clear     = r_clear;
    assign ovf       = r_ovf;
    assign resp_busy = w_seq_busy || r_buf_vld;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_uart_cmd_responder
// Description : Self-checking bench for uart_cmd_responder. Expected tx bytes
//               are queued at stimulus time and popped by a monitor on every
//               tx_start pulse. A second instance covers ECHO_EN=0.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_responder;

    localparam int BUSY_TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_done = 1'b0;
    logic       tx_busy = 1'b0;
    wire        tx_start;
    wire  [7:0] tx_data;
    wire        run, clear, resp_busy, ovf;

    logic [7:0] ne_rx_data = 8'h00;
    logic       ne_rx_done = 1'b0;
    logic       ne_tx_busy = 1'b0;
    wire        ne_tx_start;
    wire  [7:0] ne_tx_data;
    wire        ne_run, ne_clear, ne_resp_busy, ne_ovf;

    uart_cmd_responder #(.ECHO_EN(1), .BUSY_TIMEOUT(BUSY_TIMEOUT)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done),
        .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data),
        .run(run), .clear(clear), .resp_busy(resp_busy), .ovf(ovf)
    );

    uart_cmd_responder #(.ECHO_EN(0), .BUSY_TIMEOUT(BUSY_TIMEOUT)) dut_ne (
        .clk(clk), .rst(rst), .rx_data(ne_rx_data), .rx_done(ne_rx_done),
        .tx_busy(ne_tx_busy), .tx_start(ne_tx_start), .tx_data(ne_tx_data),
        .run(ne_run), .clear(ne_clear), .resp_busy(ne_resp_busy), .ovf(ne_ovf)
    );

    always #5 clk = ~clk;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] exp_q[$];
    int         start_cyc[$];
    int         cyc = 0;
    int         clear_cnt = 0;
    int         ne_clear_cnt = 0;
    int         ne_start_cnt = 0;
    int         tx_mode = 0;     // 0 normal, 1 hold busy, 2 ignore tx_start
    int         busy_cnt = 0;
    logic       prev_start = 1'b0;

    function automatic void chk(input string nm, input logic [31:0] act,
                                input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    // Transmitter model: busy for 4 cycles after each tx_start
    always @(negedge clk) begin
        if (tx_mode == 1) begin
            tx_busy = 1'b1;
        end else if (tx_mode == 2) begin
            tx_busy = 1'b0;
        end else if (tx_start) begin
            tx_busy  = 1'b1;
            busy_cnt = 4;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) tx_busy = 1'b0;
        end else begin
            tx_busy = 1'b0;
        end
    end

    // Monitor: score every tx_start pulse and count clear pulses
    always @(posedge clk) begin
        #1;
        cyc++;
        if (tx_start) begin
            chk("tx_start_while_not_busy", {31'd0, tx_busy}, 32'd0);
            chk("tx_start_single_cycle", {31'd0, prev_start}, 32'd0);
            start_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL tx_unexpected: got %0h expected none", tx_data);
            end else begin
                chk("tx_data", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
            end
        end
        prev_start = tx_start;
        if (clear) clear_cnt++;
        if (ne_clear) ne_clear_cnt++;
        if (ne_tx_start) ne_start_cnt++;
    end

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    task automatic send_ne(input logic [7:0] b);
        @(negedge clk);
        ne_rx_data = b;
        ne_rx_done = 1'b1;
        @(negedge clk);
        ne_rx_done = 1'b0;
    endtask

    task automatic expect_resp(input logic [7:0] c);
        exp_q.push_back(c);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    task automatic wait_idle(input string nm, input int limit);
        int n = 0;
        while ((resp_busy || tx_busy || exp_q.size() != 0) && n < limit) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        checks++;
        if (n >= limit) begin
            errors++;
            $display("FAIL %s_timeout: got busy after %0d cycles expected idle", nm, n);
        end
        chk({nm, "_resp_busy"}, {31'd0, resp_busy}, 32'd0);
    endtask

    task automatic check_all_zero(input string nm);
        chk({nm, "_tx_start"}, {31'd0, tx_start}, 32'd0);
        chk({nm, "_tx_data"}, {24'd0, tx_data}, 32'd0);
        chk({nm, "_run"}, {31'd0, run}, 32'd0);
        chk({nm, "_clear"}, {31'd0, clear}, 32'd0);
        chk({nm, "_resp_busy"}, {31'd0, resp_busy}, 32'd0);
        chk({nm, "_ovf"}, {31'd0, ovf}, 32'd0);
    endtask

    initial begin
        int n;
        // Reset state
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // Single command 'r' with idle transmitter
        expect_resp(8'h72);
        send(8'h72);
        chk("run_before_latency", {31'd0, run}, 32'd0);
        @(negedge clk);
        chk("run_after_r", {31'd0, run}, 32'd1);
        wait_idle("cmd_r", 200);

        // Clear command, then invalid byte
        clear_cnt = 0;
        expect_resp(8'h43);
        send(8'h43);
        repeat (2) @(negedge clk);
        chk("clear_pulse_count", clear_cnt, 32'd1);
        chk("run_kept_on_clear", {31'd0, run}, 32'd1);
        wait_idle("cmd_c", 200);
        expect_resp(8'h3F);
        send(8'h5A);
        wait_idle("cmd_invalid", 200);
        chk("run_kept_on_invalid", {31'd0, run}, 32'd1);
        chk("clear_count_after_invalid", clear_cnt, 32'd1);
        chk("ovf_before_overflow", {31'd0, ovf}, 32'd0);

        // Overflow: three commands while the transmitter stays busy
        tx_mode = 1;
        @(negedge clk);
        expect_resp(8'h72);
        expect_resp(8'h73);
        send(8'h72);
        send(8'h73);
        send(8'h74);
        repeat (1000) @(negedge clk);
        chk("ovf_set", {31'd0, ovf}, 32'd1);
        chk("run_after_rst_seq", {31'd0, run}, 32'd1);
        tx_mode = 0;
        wait_idle("overflow", 400);

        // Busy never rises: each byte advances on timeout
        tx_mode = 2;
        @(negedge clk);
        start_cyc.delete();
        expect_resp(8'h54);
        send(8'h54);
        wait_idle("timeout", 400);
        chk("timeout_pulse_count", start_cyc.size(), 32'd3);
        if (start_cyc.size() == 3) begin
            chk("timeout_gap1_range", {31'd0, (start_cyc[1] - start_cyc[0] >= BUSY_TIMEOUT) &&
                                              (start_cyc[1] - start_cyc[0] <= BUSY_TIMEOUT + 4)}, 32'd1);
            chk("timeout_gap2_range", {31'd0, (start_cyc[2] - start_cyc[1] >= BUSY_TIMEOUT) &&
                                              (start_cyc[2] - start_cyc[1] <= BUSY_TIMEOUT + 4)}, 32'd1);
        end
        chk("run_after_toggle", {31'd0, run}, 32'd0);
        tx_mode = 0;

        // Reset while waiting for busy to fall on byte 1
        start_cyc.delete();
        expect_resp(8'h52);
        send(8'h52);
        n = 0;
        while (start_cyc.size() < 2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL reset_setup: got %0d pulses expected 2", start_cyc.size());
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_all_zero("mid_reset");
        exp_q.delete();
        repeat (8) @(negedge clk);
        rst = 1'b0;
        expect_resp(8'h73);
        send(8'h73);
        wait_idle("after_reset", 200);
        chk("run_after_s", {31'd0, run}, 32'd0);
        chk("ovf_after_reset", {31'd0, ovf}, 32'd0);

        // ECHO_EN=0 instance: actions only, no transmit
        ne_clear_cnt = 0;
        send_ne(8'h74);
        @(negedge clk);
        chk("ne_run_toggle1", {31'd0, ne_run}, 32'd1);
        send_ne(8'h74);
        @(negedge clk);
        chk("ne_run_toggle2", {31'd0, ne_run}, 32'd0);
        send_ne(8'h63);
        repeat (3) @(negedge clk);
        chk("ne_clear_count", ne_clear_cnt, 32'd1);
        chk("ne_tx_start_count", ne_start_cnt, 32'd0);
        chk("ne_resp_busy", {31'd0, ne_resp_busy}, 32'd0);

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
